inst_sequencer: RTL

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// Fixed-program instruction sequencer for the attention fullchip: K load, execute, normalize, readout.
// Define INST_SEQ_READOUT_EN to compile in the READOUT phase (pmem_rd sweep); default build omits it.
module inst_sequencer #(
  parameter int COL         = 8,
  parameter int TOTAL_CYCLE = 8,
  parameter int GAP         = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [20:0] inst,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_KLOAD   = 4'd1;
  localparam logic [3:0] S_KEND    = 4'd2;
  localparam logic [3:0] S_GAP1    = 4'd3;
  localparam logic [3:0] S_EXEC    = 4'd4;
  localparam logic [3:0] S_GAP2    = 4'd5;
  localparam logic [3:0] S_NORM    = 4'd6;
`ifdef INST_SEQ_READOUT_EN
  localparam logic [3:0] S_READOUT = 4'd7;
`endif
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [3:0] K_LAST = 4'(COL + 1);
  localparam logic [3:0] E_LAST = 4'(TOTAL_CYCLE);
  localparam logic [3:0] N_LAST = 4'(TOTAL_CYCLE - 1);
  localparam logic [7:0] G_LAST = 8'(GAP - 1);

  logic [3:0]  r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_sub;
  logic [7:0]  r_gap;
  logic [20:0] r_inst;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_stateNext;
  logic [3:0]  w_cntNext;
  logic [1:0]  w_subNext;
  logic [7:0]  w_gapNext;
  logic [20:0] w_instNext;
  logic        w_busyNext;
  logic        w_doneNext;

  // r_cnt is shared as k, e, n and r; r_sub steps the four NORM sub-steps of each row.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_subNext   = r_sub;
    w_gapNext   = r_gap;
    if (abort) begin
      w_stateNext = S_IDLE;
      w_cntNext   = 4'd0;
      w_subNext   = 2'd0;
      w_gapNext   = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_stateNext = S_KLOAD;
            w_cntNext   = 4'd0;
          end
        end
        S_KLOAD: begin
          if (r_cnt == K_LAST) begin
            w_stateNext = S_KEND;
            w_cntNext   = 4'd0;
          end else begin
            w_cntNext = r_cnt + 4'd1;
          end
        end
        S_KEND: begin
          w_stateNext = S_GAP1;
          w_gapNext   = 8'd0;
        end
        S_GAP1: begin
          if (r_gap == G_LAST) begin
            w_stateNext = S_EXEC;
            w_cntNext   = 4'd0;
          end else begin
            w_gapNext = r_gap + 8'd1;
          end
        end
        S_EXEC: begin
          if (r_cnt == E_LAST) begin
            w_stateNext = S_GAP2;
            w_gapNext   = 8'd0;
          end else begin
            w_cntNext = r_cnt + 4'd1;
          end
        end
        S_GAP2: begin
          if (r_gap == G_LAST) begin
            w_stateNext = S_NORM;
            w_cntNext   = 4'd0;
            w_subNext   = 2'd0;
          end else begin
            w_gapNext = r_gap + 8'd1;
          end
        end
        S_NORM: begin
          w_subNext = r_sub + 2'd1;
          if (r_sub == 2'd3) begin
            if (r_cnt == N_LAST) begin
              w_cntNext = 4'd0;
`ifdef INST_SEQ_READOUT_EN
              w_stateNext = S_READOUT;
`else
              w_stateNext = S_DONE;
`endif
            end else begin
              w_cntNext = r_cnt + 4'd1;
            end
          end
        end
`ifdef INST_SEQ_READOUT_EN
        S_READOUT: begin
          if (r_cnt == E_LAST) begin
            w_stateNext = S_DONE;
            w_cntNext   = 4'd0;
          end else begin
            w_cntNext = r_cnt + 4'd1;
          end
        end
`endif
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered inst lines up with the state it describes.
  always_comb begin
    w_instNext = 21'd0;
    case (w_stateNext)
      S_KLOAD: begin
        w_instNext[6] = 1'b1;
        if (w_cntNext != 4'd0) begin
          w_instNext[3]     = 1'b1;
          w_instNext[15:12] = w_cntNext - 4'd1;
        end
      end
      S_KEND: w_instNext[6] = 1'b1;
      S_EXEC: begin
        w_instNext[7]     = 1'b1;
        w_instNext[5]     = 1'b1;
        w_instNext[15:12] = w_cntNext;
      end
      S_NORM: begin
        case (w_subNext)
          2'd0: w_instNext[16] = (w_cntNext != 4'd0);
          2'd1: w_instNext[18] = 1'b1;
          2'd2: begin
            w_instNext[19] = 1'b1;
            w_instNext[20] = 1'b1;
          end
          default: begin
            w_instNext[0]    = 1'b1;
            w_instNext[11:8] = w_cntNext;
          end
        endcase
      end
`ifdef INST_SEQ_READOUT_EN
      S_READOUT: begin
        w_instNext[1]    = 1'b1;
        w_instNext[11:8] = w_cntNext;
      end
`endif
      default: w_instNext = 21'd0;
    endcase
    w_busyNext = (w_stateNext != S_IDLE) && (w_stateNext != S_DONE);
    w_doneNext = (w_stateNext == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_sub   <= 2'd0;
      r_gap   <= 8'd0;
      r_inst  <= 21'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_sub   <= w_subNext;
      r_gap   <= w_gapNext;
      r_inst  <= w_instNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule
